pipe_datapath: RTL and testbench
================================

// Module: pipe_datapath
// PURPOSE
//  3-stage (DEC -> ALU -> WB) parametrised integer datapath; successor of the fixed 32-bit add-only datapath.
//  Adds a valid/stall handshake, a multi-op ALU, and destination/write-enable carried down the pipe.
//  Optional operand bypass. Sits between the decoder (drives ops) and the core top (consumes WB bus).
// PARAMETERS
//  LENGTH    32                 data width, >=8
//  NREGS     32                 register count, power of 2
//  SEL_BITS  $clog2(NREGS)      register address width
//  SH_BITS   $clog2(LENGTH)     shift-amount width (derived, do not override)
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-low
//  in_valid    in   1          op present on DEC inputs
//  in_ready    out  1          op accepted this cycle (= !stall)
//  addr_a      in   SEL_BITS   source A
//  addr_b      in   SEL_BITS   source B
//  addr_d      in   SEL_BITS   destination
//  wr_en       in   1          op writes addr_d
//  use_imm     in   1          1: B operand = imm; 0: B operand = reg[addr_b]
//  imm         in   LENGTH     immediate
//  alu_op      in   3          dp_pkg::alu_op_t
//  stall       in   1          freeze whole pipeline
//  wb_valid    out  1          WB stage holds a valid op
//  wb_wr       out  1          WB op writes the regfile this cycle
//  wb_addr     out  SEL_BITS   WB destination
//  wb_data     out  LENGTH     WB result
//  wb_z        out  1          WB result == 0
//  wb_cout     out  1          WB carry (ADD carry-out; SUB 1 = no borrow; else 0)
//  raw_hazard  out  1          comb: DEC source matches an in-flight destination not covered by bypass
// BEHAVIOUR
//  - Reset (async, reset=0): all stage valids, data regs, and wb_* cleared to 0; regfile cleared.
//    In-flight ops are discarded with no regfile write. in_ready = !stall, also during reset.
//  - Handshake: op accepted when in_valid && !stall. DEC regs capture {valid, operands, addr_d, wr_en, op}.
//  - Stall=1: every stage register holds; the regfile is not written; wb_* remain stable.
//  - Latency: accepted at edge N -> ALU stage in cycle N+1 -> wb_* valid in cycle N+2.
//    Regfile write occurs at the edge ending that WB cycle, when wb_valid && wb_wr && wb_addr!=0 && !stall.
//  - Register 0 reads as 0; writes to it are dropped (wb_wr=0 whenever wb_addr==0).
//  - Same-cycle regfile read/write: a DEC read returns the pre-write value (no write-through).
//  - ALU (mod 2^LENGTH): ADD, SUB (A+~B+1), AND, OR, XOR,
//    SLT (signed, result is 0 or 1), SLL/SRL (shift amount = B[SH_BITS-1:0]).
//  - Bubbles (valid=0) propagate with wr forced 0; their data fields are don't-care and are not checked.
// CONFIGURATION
//  BYPASS_EN defined:
//    - each source A/B compares in priority order: ALU-stage dest (valid && wr && dest!=0) first,
//      then WB-stage dest; on a match, the pending result replaces the regfile value.
//    - use_imm still overrides B.
//    - raw_hazard is tied to 0.
//  BYPASS_EN undefined:
//    - no forwarding; operands always come from the regfile.
//    - raw_hazard=1 while in_valid and a needed source (A always; B only if !use_imm), nonzero,
//      matches a valid writing ALU or WB stage.
//    - no internal stall; the decoder must stall.
// STRUCTURE
//  - Package dp_pkg: alu_op_t enum {OP_ADD=0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL};
//    struct dec_alu_t {valid, a, b, addr_d, wr, op}; struct alu_wb_t {valid, data, addr_d, wr, z, cout}.
//  - Reuses the existing regfile module.
//  - One new sub-module: dp_alu (comb; A, B, op -> C, z, cout).
// TESTING
//  1. reset=0 mid-op with ADD r1 in ALU stage, then release
//     -> wb_valid=0 throughout; r1 reads 0.
//  2. ADD r1 = r0 + imm 5 (use_imm=1), 2 bubbles, then ADD r2 = r1 + r1
//     -> wb_data=5, then wb_data=10 two cycles after the op is accepted.
//  3. Back-to-back: ADDI r3=7; SUB r4=r3-r3
//     -> BYPASS_EN: wb_data=0, wb_z=1.
//     -> no BYPASS_EN: raw_hazard=1 during the SUB's DEC cycle.
//  4. SUB 0 - 1 with LENGTH=32
//     -> wb_data=32'hFFFF_FFFF, wb_cout=0.
//     ADD FFFF_FFFF + 1 -> wb_data=0, wb_z=1, wb_cout=1.
//  5. stall=1 for 3 cycles with ops in all stages
//     -> wb_* constant, no regfile write, in_ready=0.
//     Release -> each op completes exactly once.
//  6. Write r0 (imm 9), then read r0
//     -> wb_wr=0, reads 0.
//     SLT -1,1 -> 1; SRL 8'h80 by 7 (LENGTH=8) -> 1.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types for the pipelined integer datapath: ALU opcode encoding and carry helper.
package dp_pkg;

    localparam int OP_BITS = 3;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } alu_op_t;

    // Only the adder ops report a carry; every other op drives cout low.
    function automatic logic op_has_carry(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: one shared adder for ADD/SUB, logic ops, signed compare and logical shifts.
module dp_alu
    import dp_pkg::*;
#(
    parameter int LENGTH = 32
) (
    input  logic [LENGTH-1:0] a,
    input  logic [LENGTH-1:0] b,
    input  alu_op_t           op,
    output logic [LENGTH-1:0] c,
    output logic              z,
    output logic              cout
);

    localparam int SH_BITS = $clog2(LENGTH);

    logic              is_sub;
    logic [LENGTH-1:0] b_add;
    logic [LENGTH:0]   sum;
    logic [SH_BITS-1:0] shamt;
    logic              lt;

    // SUB is A + ~B + 1, so carry-out 1 means no borrow.
    assign is_sub = (op == OP_SUB);
    assign b_add  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_add} + {{LENGTH{1'b0}}, is_sub};
    assign shamt  = b[SH_BITS-1:0];
    assign lt     = ($signed(a) < $signed(b));

    always_comb begin
        c = '0;
        case (op)
            OP_ADD: c = sum[LENGTH-1:0];
            OP_SUB: c = sum[LENGTH-1:0];
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            OP_SLT: c = {{(LENGTH-1){1'b0}}, lt};
            OP_SLL: c = a << shamt;
            OP_SRL: c = a >> shamt;
        endcase
    end

    assign z    = (c == '0);
    assign cout = op_has_carry(op) & sum[LENGTH];

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file with async active-low clear; register 0 is hardwired to zero.
module regfile #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int SEL_BITS = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [SEL_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [SEL_BITS-1:0] raddr_a,
    input  logic [SEL_BITS-1:0] raddr_b,
    output logic [WIDTH-1:0]    rdata_a,
    output logic [WIDTH-1:0]    rdata_b
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-write contents in the cycle a write is pending.
    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/pipe_datapath.sv
// 3-stage DEC -> ALU -> WB integer datapath with valid/stall handshake.
// Define BYPASS_EN to forward ALU/WB results into DEC operands; otherwise raw_hazard flags conflicts.
module pipe_datapath
    import dp_pkg::*;
#(
    parameter int LENGTH   = 32,
    parameter int NREGS    = 32,
    parameter int SEL_BITS = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_BITS-1:0] addr_a,
    input  logic [SEL_BITS-1:0] addr_b,
    input  logic [SEL_BITS-1:0] addr_d,
    input  logic                wr_en,
    input  logic                use_imm,
    input  logic [LENGTH-1:0]   imm,
    input  logic [OP_BITS-1:0]  alu_op,
    input  logic                stall,
    output logic                wb_valid,
    output logic                wb_wr,
    output logic [SEL_BITS-1:0] wb_addr,
    output logic [LENGTH-1:0]   wb_data,
    output logic                wb_z,
    output logic                wb_cout,
    output logic                raw_hazard
);

    // Stage records; widths track the module parameters.
    typedef struct packed {
        logic                valid;
        logic [LENGTH-1:0]   a;
        logic [LENGTH-1:0]   b;
        logic [SEL_BITS-1:0] addr_d;
        logic                wr;
        alu_op_t             op;
    } dec_alu_t;

    typedef struct packed {
        logic                valid;
        logic [LENGTH-1:0]   data;
        logic [SEL_BITS-1:0] addr_d;
        logic                wr;
        logic                z;
        logic                cout;
    } alu_wb_t;

    dec_alu_t          alu_q;
    alu_wb_t           wb_q;
    logic [LENGTH-1:0] rf_a, rf_b;
    logic [LENGTH-1:0] src_a, src_b, opnd_b;
    logic [LENGTH-1:0] alu_c;
    logic              alu_z, alu_cout;
    logic              rf_we;
    logic              hit_alu_a, hit_wb_a, hit_alu_b, hit_wb_b;

    // Handshake: an op is taken at a rising edge when in_valid && in_ready.
    // in_ready is !stall and never depends on in_valid, including during reset.
    assign in_ready = !stall;

    assign rf_we = wb_q.valid && wb_q.wr && !stall;

    regfile #(
        .WIDTH   (LENGTH),
        .NREGS   (NREGS),
        .SEL_BITS(SEL_BITS)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (wb_q.addr_d),
        .wdata  (wb_q.data),
        .raddr_a(addr_a),
        .raddr_b(addr_b),
        .rdata_a(rf_a),
        .rdata_b(rf_b)
    );

    dp_alu #(
        .LENGTH(LENGTH)
    ) u_alu (
        .a   (alu_q.a),
        .b   (alu_q.b),
        .op  (alu_q.op),
        .c   (alu_c),
        .z   (alu_z),
        .cout(alu_cout)
    );

    // Stage wr bits are qualified with valid and dest!=0 at capture, so a hit never names r0.
    assign hit_alu_a = alu_q.wr && (alu_q.addr_d == addr_a);
    assign hit_wb_a  = wb_q.wr  && (wb_q.addr_d  == addr_a);
    assign hit_alu_b = alu_q.wr && (alu_q.addr_d == addr_b);
    assign hit_wb_b  = wb_q.wr  && (wb_q.addr_d  == addr_b);

`ifdef BYPASS_EN
    // The younger ALU-stage result wins over the WB-stage result.
    always_comb begin
        src_a = rf_a;
        if (hit_alu_a) begin
            src_a = alu_c;
        end else if (hit_wb_a) begin
            src_a = wb_q.data;
        end
        src_b = rf_b;
        if (hit_alu_b) begin
            src_b = alu_c;
        end else if (hit_wb_b) begin
            src_b = wb_q.data;
        end
    end

    assign raw_hazard = 1'b0;
`else
    assign src_a = rf_a;
    assign src_b = rf_b;

    assign raw_hazard = in_valid &&
                        (((addr_a != '0) && (hit_alu_a || hit_wb_a)) ||
                         (!use_imm && (addr_b != '0) && (hit_alu_b || hit_wb_b)));
`endif

    assign opnd_b = use_imm ? imm : src_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q <= '0;
            wb_q  <= '0;
        end else if (!stall) begin
            alu_q.valid  <= in_valid;
            alu_q.a      <= src_a;
            alu_q.b      <= opnd_b;
            alu_q.addr_d <= addr_d;
            alu_q.wr     <= in_valid && wr_en && (addr_d != '0);
            alu_q.op     <= alu_op_t'(alu_op);

            wb_q.valid   <= alu_q.valid;
            wb_q.data    <= alu_c;
            wb_q.addr_d  <= alu_q.addr_d;
            wb_q.wr      <= alu_q.wr;
            wb_q.z       <= alu_z;
            wb_q.cout    <= alu_cout;
        end
    end

    assign wb_valid = wb_q.valid;
    assign wb_wr    = wb_q.wr;
    assign wb_addr  = wb_q.addr_d;
    assign wb_data  = wb_q.data;
    assign wb_z     = wb_q.z;
    assign wb_cout  = wb_q.cout;

endmodule

// File: tb/tb_pipe_datapath.sv
// Scoreboard bench for pipe_datapath: directed corner cases plus randomized op streams
// checked against an architectural (in-order, one-op-at-a-time) model.
module tb_pipe_datapath;
    import dp_pkg::*;

    localparam int LENGTH   = 32;
    localparam int NREGS    = 32;
    localparam int SEL_BITS = 5;
    localparam int W        = 1 + SEL_BITS + 1 + 1 + LENGTH;  // {wr, addr, z, cout, data}

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [SEL_BITS-1:0] addr_a = '0, addr_b = '0, addr_d = '0;
    logic                wr_en = 1'b0, use_imm = 1'b0;
    logic [LENGTH-1:0]   imm = '0;
    logic [2:0]          alu_op = '0;
    logic                stall = 1'b0;
    logic                wb_valid, wb_wr, wb_z, wb_cout, raw_hazard;
    logic [SEL_BITS-1:0] wb_addr;
    logic [LENGTH-1:0]   wb_data;

    pipe_datapath #(
        .LENGTH  (LENGTH),
        .NREGS   (NREGS),
        .SEL_BITS(SEL_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .addr_d    (addr_d),
        .wr_en     (wr_en),
        .use_imm   (use_imm),
        .imm       (imm),
        .alu_op    (alu_op),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_wr     (wb_wr),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_z      (wb_z),
        .wb_cout   (wb_cout),
        .raw_hazard(raw_hazard)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [W-1:0]      exp_q[$];
    logic [LENGTH-1:0] model_rf [NREGS];
    // Destinations accepted but not yet retired: the op one edge old and two edges old.
    logic              sa_v = 1'b0, sa_wr = 1'b0, sw_v = 1'b0, sw_wr = 1'b0;
    logic [SEL_BITS-1:0] sa_d = '0, sw_d = '0;
    logic              adv_q = 1'b0;
    logic [W:0]        prev_wb = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Architectural result of one op.
    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [LENGTH-1:0] a,
                                            input logic [LENGTH-1:0] b, input logic [SEL_BITS-1:0] d,
                                            input logic we);
        longint ua, ub;
        logic [LENGTH-1:0] r;
        logic co;
        ua = longint'(a);
        ub = longint'(b);
        r  = '0;
        co = 1'b0;
        case (op)
            3'd0: begin r = a + b; co = ((ua + ub) >= (longint'(1) << LENGTH)); end
            3'd1: begin r = a - b; co = (ua >= ub); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: if ($signed(a) < $signed(b)) r[0] = 1'b1;
            3'd6: r = a << (b % LENGTH);
            default: r = a >> (b % LENGTH);
        endcase
        return {we && (d != '0), d, (r == '0), co, r};
    endfunction

    function automatic logic exp_hazard(input logic [SEL_BITS-1:0] a, input logic [SEL_BITS-1:0] b,
                                        input logic ui);
        logic na, nb, h;
        na = (a != '0);
        nb = !ui && (b != '0);
        h  = (sa_v && sa_wr && ((na && sa_d == a) || (nb && sa_d == b))) ||
             (sw_v && sw_wr && ((na && sw_d == a) || (nb && sw_d == b)));
`ifdef BYPASS_EN
        h = 1'b0;
`endif
        return h;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
        sa_v = 0; sa_wr = 0; sa_d = '0;
        sw_v = 0; sw_wr = 0; sw_d = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic advance(input logic v, input logic we, input logic [SEL_BITS-1:0] d);
        @(posedge clk);
        if (!stall && reset) begin
            sw_v = sa_v; sw_wr = sa_wr; sw_d = sa_d;
            sa_v = v; sa_wr = v && we && (d != '0); sa_d = d;
        end
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [SEL_BITS-1:0] a, input logic [SEL_BITS-1:0] b,
                         input logic [SEL_BITS-1:0] d, input logic we, input logic ui,
                         input logic [LENGTH-1:0] iv);
        logic [LENGTH-1:0] va, vb;
        logic [W-1:0] e;
        logic hz;
        alu_op = op; addr_a = a; addr_b = b; addr_d = d; wr_en = we; use_imm = ui; imm = iv;
        stall = 1'b0;
        hz = 1'b0;
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            #2;
            hz = exp_hazard(a, b, ui);
            check("raw_hazard", raw_hazard, hz);
            check("in_ready", in_ready, !stall);
            if (!hz) begin
                va = model_rf[a];
                vb = ui ? iv : model_rf[b];
                e  = ref_op(op, va, vb, d, we);
                exp_q.push_back(e);
                if (we && d != '0) model_rf[d] = e[LENGTH-1:0];
                advance(1'b1, we, d);
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b0;
            advance(1'b0, 1'b0, '0);
        end
        check("hazard_clears", hz, 1'b0);
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        stall = 1'b0;
        #2;
        check("raw_hazard_idle", raw_hazard, 1'b0);
        advance(1'b0, 1'b0, '0);
    endtask

    // Freeze the pipe with a live op waiting in DEC; it must not be taken.
    task automatic stall_cycles(input int n);
        stall = 1'b1;
        in_valid = 1'b1;
        alu_op = 3'($urandom_range(0, 7));
        addr_d = SEL_BITS'($urandom_range(1, 7));
        wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            #2;
            check("in_ready_stall", in_ready, !stall);
            advance(1'b0, 1'b0, '0);
        end
        stall = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        in_valid = 1'b0;
        stall = 1'b0;
        clear_model();
        for (int i = 0; i < n; i++) begin
            #2;
            check("in_ready_reset", in_ready, !stall);
            stall = 1'b1;
            #1;
            check("in_ready_reset_stall", in_ready, !stall);
            stall = 1'b0;
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) adv_q <= reset && !stall;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset) begin
            check("wb_valid_reset", wb_valid, 1'b0);
            check("wb_data_reset", wb_data, '0);
            check("wb_wr_reset", wb_wr, 1'b0);
        end else if (!adv_q) begin
            check("wb_hold", {wb_valid, wb_wr, wb_addr, wb_z, wb_cout, wb_data}, prev_wb);
        end else if (wb_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got wb_valid=1 data=%0h, expected no output (t=%0t)", wb_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("wb_wr", wb_wr, e[W-1]);
                check("wb_addr", wb_addr, e[W-2 -: SEL_BITS]);
                check("wb_z", wb_z, e[LENGTH+1]);
                check("wb_cout", wb_cout, e[LENGTH]);
                check("wb_data", wb_data, e[LENGTH-1:0]);
            end
        end
        prev_wb = {wb_valid, wb_wr, wb_addr, wb_z, wb_cout, wb_data};
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected completion within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [LENGTH-1:0] iv;
        int k;
        clear_model();
        do_reset(3);

        // Reset while ADD r1 sits in the ALU stage; r1 must read back 0.
        issue(OP_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5);
        do_reset(2);
        bubble();
        issue(OP_ADD, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 32'd0);

        // r1 = 5, two bubbles, r2 = r1 + r1.
        issue(OP_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5);
        bubble();
        bubble();
        issue(OP_ADD, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 32'd0);

        // Back-to-back dependency.
        issue(OP_ADD, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'd7);
        issue(OP_SUB, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 32'd0);

        // Borrow and carry boundaries.
        issue(OP_SUB, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 32'd1);
        issue(OP_ADD, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 32'd1);

        // Stall with every stage occupied.
        issue(OP_ADD, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'd11);
        issue(OP_XOR, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h55);
        stall_cycles(3);
        issue(OP_OR, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'h100);
        bubble();
        bubble();
        issue(OP_OR, 5'd8, 5'd9, 5'd11, 1'b1, 1'b0, 32'd0);

        // r0 write dropped, SLT and SRL corners.
        issue(OP_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd9);
        issue(OP_ADD, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 32'd0);
        issue(OP_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue(OP_SLT, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 32'd1);
        issue(OP_ADD, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'h80);
        issue(OP_SRL, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 32'd7);

        // Randomized stream over a small register window to provoke dependencies.
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 11);
            if (k == 0) begin
                bubble();
            end else if (k == 1) begin
                stall_cycles($urandom_range(1, 3));
            end else begin
                case ($urandom_range(0, 5))
                    0: iv = 32'd0;
                    1: iv = 32'hFFFF_FFFF;
                    2: iv = 32'h8000_0000;
                    3: iv = 32'($urandom_range(0, 40));
                    default: iv = $urandom;
                endcase
                issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), iv);
            end
        end

        for (int i = 0; i < 4; i++) bubble();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
